// File: rtl/ahb_delay_ctrl.sv
// ahb_delay_ctrl: programmable per-transfer delay source for the AHB read-delay FIFO, with transfer/stall counters
module ahb_delay_ctrl #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          DELAY_W   = 16
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst_b,
  input  logic [1:0]  biu_pad_htrans,
  input  logic        fifo_biu_hready,
  input  logic        cfg_sel,
  input  logic        cfg_wr,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic [31:0] counter_num0
);
  logic [1:0]         mode, n_mode;
  logic [DELAY_W-1:0] base, lim, cur, n_base, n_lim, cur_nxt, sweep_nxt;
  logic [15:0]        lfsr, lfsr_nxt;
  logic [31:0]        xfer_cnt, stall_cnt, rd_val;
  logic               accept, stall, wr_ctrl, wr_delay, cfg_write, cnt_clr;
  logic               unused_addr;

  function automatic logic [DELAY_W-1:0] sat_add(input logic [DELAY_W-1:0] b, input logic [DELAY_W-1:0] m);
    logic [DELAY_W:0] s;
    s = {1'b0, b} + {1'b0, m};
    return s[DELAY_W] ? '1 : s[DELAY_W-1:0];
  endfunction

  assign accept      = biu_pad_htrans[1] && fifo_biu_hready;
  assign stall       = biu_pad_htrans[1] && !fifo_biu_hready;
  assign wr_ctrl     = cfg_sel && cfg_wr && cfg_addr[3:2] == 2'd0;
  assign wr_delay    = cfg_sel && cfg_wr && cfg_addr[3:2] == 2'd1;
  assign cfg_write   = wr_ctrl || wr_delay;
  assign cnt_clr     = wr_ctrl && cfg_wdata[2];
  assign unused_addr = ^cfg_addr[1:0];

  assign n_mode   = wr_ctrl  ? cfg_wdata[1:0]         : mode;
  assign n_base   = wr_delay ? cfg_wdata[DELAY_W-1:0] : base;
  assign n_lim    = wr_delay ? cfg_wdata[16+:DELAY_W] : lim;
  assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  // a config write reloads from the freshly written values and uses the pre-shift LFSR
  always_comb begin
    sweep_nxt = (lim < base || cur >= lim) ? base : cur + DELAY_W'(1);
    cur_nxt   = cfg_write ? (n_mode == 2'd0 ? '0 :
                             n_mode == 2'd2 ? sat_add(n_base, DELAY_W'(lfsr) & n_lim) : n_base)
                          : (mode == 2'd0 ? '0 :
                             mode == 2'd1 ? base :
                             mode == 2'd2 ? sat_add(base, DELAY_W'(lfsr_nxt) & lim) : sweep_nxt);
    rd_val    = cfg_addr[3:2] == 2'd0 ? {30'b0, mode} :
                cfg_addr[3:2] == 2'd1 ? {16'(lim), 16'(base)} :
                cfg_addr[3:2] == 2'd2 ? xfer_cnt : stall_cnt;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
    if (!cpu_rst_b) begin
      mode      <= '0;
      base      <= '0;
      lim       <= '0;
      cur       <= '0;
      lfsr      <= LFSR_SEED;
      xfer_cnt  <= '0;
      stall_cnt <= '0;
      cfg_rdata <= '0;
    end else begin
      mode      <= n_mode;
      base      <= n_base;
      lim       <= n_lim;
      if (cfg_write || accept) cur <= cur_nxt;
      if (accept) lfsr <= lfsr_nxt;
      xfer_cnt  <= cnt_clr ? '0 : (accept && !(&xfer_cnt)) ? xfer_cnt + 32'd1 : xfer_cnt;
      stall_cnt <= cnt_clr ? '0 : (stall && !(&stall_cnt)) ? stall_cnt + 32'd1 : stall_cnt;
      if (cfg_sel && !cfg_wr) cfg_rdata <= rd_val;
    end
  end

  assign counter_num0 = {{(32-DELAY_W){1'b0}}, cur};
endmodule

// File: doc/ahb_delay_ctrl.md
# ahb_delay_ctrl

Programmable delay scheduler for the AHB read-delay FIFO. It drives the FIFO's per-transaction delay load value (`counter_num0`) from a small register file. Four modes are supported: off, fixed, pseudo-random and sweep. It also counts accepted transfers and master stall cycles for latency characterisation. It sits beside the FIFO on the BIU-to-pad path and is programmed by the testbench/SoC control port.

## Interface

Parameters:
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
- DELAY_W, 16, width of the active delay value; `counter_num0` upper bits are zero.

Ports:
- cpu_clk  input  1  clock.
- cpu_rst_b  input  1  reset, asynchronous, active-low.
- biu_pad_htrans  input  2  master HTRANS; bit 1 marks NONSEQ/SEQ.
- fifo_biu_hready  input  1  HREADY seen by the master (FIFO output).
- cfg_sel  input  1  config access strobe, single cycle.
- cfg_wr  input  1  1 = write, 0 = read; qualified by cfg_sel.
- cfg_addr  input  4  byte address; bits [3:2] select the register.
- cfg_wdata  input  32  write data.
- cfg_rdata  output  32  read data, registered.
- counter_num0  output  32  delay load value to the FIFO.

## Operation

Registers:
- 0x0 CTRL:
  - [1:0] MODE: 0 off, 1 fixed, 2 random, 3 sweep.
  - [2] CNT_CLR: write-1 pulse, reads 0.
  - Other bits read 0.
- 0x4 DELAY:
  - [15:0] BASE.
  - [31:16] LIM. In random mode this is the mask; in sweep mode it is the upper bound.
- 0x8 XFER_CNT: RO, saturating at 32'hFFFFFFFF.
- 0xC STALL_CNT: RO, saturating at 32'hFFFFFFFF.
- Writes to RO registers are ignored.

Events:
- accept = biu_pad_htrans[1] && fifo_biu_hready.
- stall = biu_pad_htrans[1] && !fifo_biu_hready.
- cfg_write = cfg_sel && cfg_wr to CTRL or DELAY.

Delay register `cur` (DELAY_W bits); counter_num0 = {16'b0, cur}:
- Off: cur = 0, which makes the FIFO bypass all transfers.
- Fixed: cur = BASE.
- Random: on each accept, cur = min(BASE + (lfsr_next & LIM), 16'hFFFF). The sum is computed 17-bit, then saturated.
- Sweep: on each accept, cur = cur+1. If cur >= LIM, cur returns to BASE. If LIM < BASE, cur holds at BASE.

On cfg_write, cur reloads next cycle from the new register values:
- Off: 0.
- Fixed or sweep: BASE.
- Random: BASE + (lfsr & LIM), saturated.

LFSR:
- 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
- Shifts once per accept in every mode.
- Never reset by config writes.

Counters:
- XFER_CNT increments on accept; STALL_CNT increments on stall.
- Both clear on a CNT_CLR write.

## Timing

- Reset values:
  - cfg_rdata = 0, counter_num0 = 0, MODE = 0, DELAY = 0.
  - Both counters = 0, lfsr = LFSR_SEED.
- counter_num0 is a flop output and changes only in the cycle after an accept or cfg_write. It is therefore stable through every address phase in which the FIFO may load it.
- Read latency:
  - cfg_rdata is valid the cycle after cfg_sel && !cfg_wr.
  - It holds its value until the next read.
  - Counter reads return the value before that cycle's increment.
- Write takes effect at the next clock edge; the effect on cur is visible one cycle after the write cycle.
- Simultaneous events:
  - cfg_write and accept in the same cycle: cfg_write determines cur, and the LFSR still advances.
  - CNT_CLR and accept/stall in the same cycle: the clear wins and the counter becomes 0.
- Saturation: counters stay at all-ones, with no wrap.
- Async reset mid-operation returns all state to reset values immediately. The first delay after reset is 0 until MODE is written.

## Test plan

- Reset check: read all four registers after reset -> all read 0; counter_num0 = 0; 10 accepts while in off mode give XFER_CNT = 10.
- Fixed mode: write DELAY = 32'h0000_0005 and CTRL = 1 -> counter_num0 = 5 one cycle after the write; 4 accepts leave it at 5.
- Random mode: seed ACE1, BASE = 2, LIM = 16'h000F, CTRL = 2, then 3 accepts. Required: each value = 2 + (reference-LFSR & 0xF), within 2..17. With BASE = 16'hFFF0 and LIM = 16'h00FF, the output saturates at 16'hFFFF.
- Sweep mode: BASE = 3, LIM = 5, then 6 accepts -> sequence 4, 5, 3, 4, 5, 3. With LIM = 1 and BASE = 3, the value stays at 3.
- Counters:
  - 7 stall cycles then 2 accepts -> STALL_CNT = 7, XFER_CNT = 2.
  - CNT_CLR written in the same cycle as an accept -> both read 0.
  - Force XFER_CNT to FFFFFFFF, then one more accept -> it still reads FFFFFFFF.
- Collision and reset: a DELAY write in the same cycle as an accept in sweep mode -> cur = new BASE. Assert cpu_rst_b low mid-sweep -> counter_num0 = 0 asynchronously, and the LFSR is reseeded.
